// File: rtl/pwm_fade_sequencer.sv
// Multi-channel LED fade sequencer: one shared fade-tick prescaler, one shared PWM counter,
// and a per-channel breathing FSM whose modes are set through a valid/ready command port.
module pwm_fade_sequencer #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned TICK_DIV   = 10000,
    parameter int unsigned HOLD_TICKS = 64,
    localparam int unsigned CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CHW-1:0]  cmd_ch,
    input  logic [1:0]      cmd_mode,
    output logic            cmd_err,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] breathing,
    output logic            fade_tick
);

    localparam int unsigned PSW = $clog2(TICK_DIV);
    localparam int unsigned HW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PSW-1:0]      PRESC_LAST = PSW'(TICK_DIV - 1);
    localparam logic [HW-1:0]       HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [PWM_BITS-1:0] DMAX       = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

    localparam logic [1:0] ModeOff     = 2'b00;
    localparam logic [1:0] ModeOn      = 2'b01;
    localparam logic [1:0] ModeBreathe = 2'b10;

    typedef enum logic [2:0] {
        StOff, StOn, StUp, StHoldHi, StDown, StHoldLo, StFrozen
    } state_e;

    logic [PSW-1:0]      presc_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                fade_tick_q;
    logic                cmd_err_q;
    logic [N_CH-1:0]     led_q;
    logic [N_CH-1:0]     breathing_q;

    state_e              state_q [N_CH];
    state_e              state_d [N_CH];
    logic [PWM_BITS-1:0] duty_q  [N_CH];
    logic [PWM_BITS-1:0] duty_d  [N_CH];
    logic [HW-1:0]       hold_q  [N_CH];
    logic [HW-1:0]       hold_d  [N_CH];

    logic tick;
    logic cmd_acc;
    logic ch_ok;

    // Tick always wins: commands are held off for the tick cycle so the two never collide.
    assign tick      = (presc_q == PRESC_LAST);
    assign cmd_ready = !rst && !tick;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign ch_ok     = (32'(cmd_ch) < N_CH);

    assign fade_tick = fade_tick_q;
    assign cmd_err   = cmd_err_q;
    assign led       = led_q;
    assign breathing = breathing_q;

    function automatic logic is_breath(input state_e s);
        return (s == StUp) || (s == StHoldHi) || (s == StDown) || (s == StHoldLo);
    endfunction

    // Shared prescaler, PWM counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            pwm_q       <= '0;
            fade_tick_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            led_q       <= '0;
            breathing_q <= '0;
        end else begin
            presc_q     <= tick ? '0 : presc_q + PSW'(1);
            pwm_q       <= pwm_q + DUTY_ONE;
            fade_tick_q <= tick;
            cmd_err_q   <= cmd_acc && !ch_ok;
            for (int i = 0; i < N_CH; i++) begin
                led_q[i]       <= (pwm_q < duty_q[i]);
                breathing_q[i] <= is_breath(state_q[i]);
            end
        end
    end

    // Per-channel state, duty and hold registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                state_q[i] <= StOff;
                duty_q[i]  <= '0;
                hold_q[i]  <= '0;
            end else begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // Next-state: fade step on tick, otherwise an accepted command for this channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            duty_d[i]  = duty_q[i];
            hold_d[i]  = hold_q[i];
            if (tick) begin
                case (state_q[i])
                    StUp: begin
                        if (duty_q[i] != DMAX) duty_d[i] = duty_q[i] + DUTY_ONE;
                        if (duty_q[i] >= DMAX - DUTY_ONE) begin
                            state_d[i] = StHoldHi;
                            hold_d[i]  = '0;
                        end
                    end
                    StHoldHi: begin
                        if (hold_q[i] == HOLD_LAST) state_d[i] = StDown;
                        else                        hold_d[i]  = hold_q[i] + HW'(1);
                    end
                    StDown: begin
                        if (duty_q[i] != '0) duty_d[i] = duty_q[i] - DUTY_ONE;
                        if (duty_q[i] <= DUTY_ONE) begin
                            state_d[i] = StHoldLo;
                            hold_d[i]  = '0;
                        end
                    end
                    StHoldLo: begin
                        if (hold_q[i] == HOLD_LAST) state_d[i] = StUp;
                        else                        hold_d[i]  = hold_q[i] + HW'(1);
                    end
                    default: ;
                endcase
            end else if (cmd_acc && ch_ok && (cmd_ch == CHW'(i))) begin
                case (cmd_mode)
                    ModeOff: begin
                        duty_d[i]  = '0;
                        state_d[i] = StOff;
                    end
                    ModeOn: begin
                        duty_d[i]  = DMAX;
                        state_d[i] = StOn;
                    end
                    ModeBreathe: begin
                        // Continue from the present brightness; at full scale start holding.
                        if (duty_q[i] == DMAX) begin
                            state_d[i] = StHoldHi;
                            hold_d[i]  = '0;
                        end else begin
                            state_d[i] = StUp;
                        end
                    end
                    default: state_d[i] = StFrozen;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: expected duty steps and error pulses are queued by
// the stimulus and popped by a monitor whenever the DUT presents fade_tick / cmd_err.
module tb_pwm_fade_sequencer;

    localparam int unsigned N_CH       = 5;
    localparam int unsigned PWM_BITS   = 3;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned HOLD_TICKS = 2;
    localparam int unsigned CHW        = 3;

    localparam int M_OFF = 0, M_ON = 1, M_BREATHE = 2, M_FREEZE = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [CHW-1:0]  cmd_ch = '0;
    logic [1:0]      cmd_mode = '0;
    logic            cmd_err;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] breathing;
    logic            fade_tick;

    int total = 0;
    int bad   = 0;
    int duty_exp[$];
    int err_exp[$];
    int tcnt = 0;
    logic exp_ft = 1'b0;
    logic mon_en = 1'b0;

    pwm_fade_sequencer #(
        .N_CH(N_CH), .PWM_BITS(PWM_BITS), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_err(cmd_err), .led(led),
        .breathing(breathing), .fade_tick(fade_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference prescaler phase used to predict tick-related outputs.
    always @(posedge clk) begin
        if (rst) begin
            tcnt   <= 0;
            exp_ft <= 1'b0;
        end else begin
            tcnt   <= (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
            exp_ft <= (tcnt == TICK_DIV - 1);
        end
    end

    // Monitor: per-cycle handshake/tick checks, plus scoreboard pops on DUT output events.
    always @(negedge clk) begin
        if (mon_en) begin
            check("cmd_ready", int'(cmd_ready), int'(!rst && (tcnt != TICK_DIV - 1)));
            check("fade_tick", int'(fade_tick), int'(exp_ft));
            if (fade_tick && duty_exp.size() > 0)
                check("duty_ch1", int'(dut.duty_q[1]), duty_exp.pop_front());
            if (cmd_err) begin
                total++;
                if (err_exp.size() == 0) begin
                    bad++;
                    $display("FAIL cmd_err: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    void'(err_exp.pop_front());
                end
            end
        end
    end

    task automatic send(input int ch, input int mode, output int stalls);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_ch    = CHW'(ch);
        cmd_mode  = 2'(mode);
        stalls    = 0;
        @(negedge clk);
        while (!cmd_ready && stalls < 8) begin
            stalls++;
            @(negedge clk);
        end
        check("cmd_accept", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 400 && duty_exp.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check(name, duty_exp.size(), 0);
        duty_exp.delete();
    endtask

    task automatic count_led(input int bit_idx, output int ones, output int others);
        ones = 0;
        others = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (led[bit_idx]) ones++;
            for (int b = 0; b < N_CH; b++) if (b != bit_idx && led[b]) others++;
        end
    endtask

    task automatic check_duties(input string name, input int d0, input int d1, input int d2);
        check({name, "_d0"}, int'(dut.duty_q[0]), d0);
        check({name, "_d1"}, int'(dut.duty_q[1]), d1);
        check({name, "_d2"}, int'(dut.duty_q[2]), d2);
        check({name, "_d3"}, int'(dut.duty_q[3]), 0);
        check({name, "_d4"}, int'(dut.duty_q[4]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, ones, others;
        int seq_a[19] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1};

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_breathing", int'(breathing), 0);
        check("rst_cmd_err", int'(cmd_err), 0);
        @(posedge clk); #1 rst = 1'b0;

        // ON ch0: 7 of every 8 cycles high, other channels dark.
        send(0, M_ON, s);
        repeat (2) @(posedge clk);
        count_led(0, ones, others);
        check("on_led0_high", ones, 14);
        check("on_other_leds", others, 0);

        // BREATHE ch1 from dark: one full breath plus the first step of the next.
        send(1, M_BREATHE, s);
        foreach (seq_a[k]) duty_exp.push_back(seq_a[k]);
        @(posedge clk); @(negedge clk);
        check("breathing_on", int'(breathing), 2);
        drain("breath_full");

        // FREEZE at duty 4 mid-UP, then resume.
        duty_exp.push_back(2); duty_exp.push_back(3); duty_exp.push_back(4);
        drain("up_to_4");
        send(1, M_FREEZE, s);
        duty_exp.push_back(4); duty_exp.push_back(4);
        @(posedge clk); @(negedge clk);
        check("breathing_frozen", int'(breathing), 0);
        drain("frozen_4");
        send(1, M_BREATHE, s);
        duty_exp.push_back(5); duty_exp.push_back(6);
        drain("resume_5_6");

        // Command presented on the tick cycle: stalls one cycle, tick step uses old mode (UP).
        do @(negedge clk); while (tcnt != 2);
        duty_exp.push_back(7);
        send(1, M_FREEZE, s);
        check("tick_stall", s, 1);
        duty_exp.push_back(7);
        drain("tick_old_mode");
        check("breathing_after_freeze", int'(breathing), 0);

        // BREATHE issued at full scale starts in the high hold.
        send(1, M_BREATHE, s);
        duty_exp.push_back(7); duty_exp.push_back(7); duty_exp.push_back(6);
        drain("breathe_at_max");
        send(1, M_FREEZE, s);
        duty_exp.push_back(6);
        drain("frozen_6");

        // Out-of-range channels: one-cycle error pulse, nothing changes.
        send(5, M_OFF, s);
        err_exp.push_back(5);
        repeat (2) @(posedge clk);
        check_duties("err5", 7, 6, 0);
        send(7, M_ON, s);
        err_exp.push_back(7);
        repeat (3) @(posedge clk);
        check_duties("err7", 7, 6, 0);
        check("err_pulses_seen", err_exp.size(), 0);

        // OFF ch0 goes dark.
        send(0, M_OFF, s);
        repeat (2) @(posedge clk);
        count_led(0, ones, others);
        check("off_led0_high", ones, 0);

        // Reset mid-operation, held three cycles.
        send(0, M_ON, s);
        send(2, M_BREATHE, s);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_led", int'(led), 0);
            check("midrst_breathing", int'(breathing), 0);
            check("midrst_cmd_ready", int'(cmd_ready), 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("release_cmd_ready", int'(cmd_ready), 1);
        check_duties("midrst", 0, 0, 0);
        count_led(0, ones, others);
        check("midrst_led0_dark", ones, 0);
        check("midrst_others_dark", others, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
